// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register of the RISC-V Lite core.
//
// Captures register_file read data (with a write-through bypass from MEM/WB),
// the decoded immediate and control into the ID/EX register. It detects hazards
// that need a stall and drives stall_o towards PC / IF-ID.
//
// Build option (macro RVL_ID_EX_FORWARDING_EN):
//   defined   : EX operands are forwarded from EX/MEM and MEM/WB. Only a
//               load-use hazard stalls, for one bubble.
//   undefined : no forwarding. Any RAW on a producer in EX or EX/MEM stalls
//               until the producer reaches WB, where write-through resolves it.
//
// Ports
//   clk, RST        clock, asynchronous active-high reset
//   en              stage enable (0 = hold all state, no stall)
//   flush           kill the instruction entering EX
//   id_*            instruction in ID: sources, destination, read data,
//                   immediate, control, load / write flags
//   exm_*           EX/MEM destination, write flag, ALU result
//   wb_*            MEM/WB destination, write strobe, write data
//   stall_o         hold PC and IF/ID this cycle
//   ex_*            registered EX-side instruction, with forwarded operands
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [4:0]        exm_rd,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [4:0]        wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    logic [0:0]      state;
    logic [1:0]      cnt;         // bubbles still to insert after the current one
    logic [XLEN-1:0] ex_v1, ex_v2; // operand values captured at the ID/EX edge
    logic [XLEN-1:0] cap1, cap2;
    logic            hazard;
    logic [1:0]      hz_bubbles;
    logic            stall_raw;

    // register_file does not bypass its own write port, so a same-cycle WB
    // write to the register being read is picked up here. x0 reads as 0.
    assign cap1 = (id_rs1 == 5'd0) ? '0 :
                  (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rdata1;
    assign cap2 = (id_rs2 == 5'd0) ? '0 :
                  (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rdata2;

`ifdef RVL_ID_EX_FORWARDING_EN
    logic [4:0] ex_rs1, ex_rs2;

    assign hazard = ex_valid && ex_mem_read && ex_rd != 5'd0 && id_valid &&
                    (ex_rd == id_rs1 || ex_rd == id_rs2);
    assign hz_bubbles = 2'd1;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    assign ex_op1 = (exm_reg_write && exm_rd != 5'd0 && exm_rd == ex_rs1) ? exm_result :
                    (wb_reg_write  && wb_rd  != 5'd0 && wb_rd  == ex_rs1) ? wb_data    : ex_v1;
    assign ex_op2 = (exm_reg_write && exm_rd != 5'd0 && exm_rd == ex_rs2) ? exm_result :
                    (wb_reg_write  && wb_rd  != 5'd0 && wb_rd  == ex_rs2) ? wb_data    : ex_v2;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (en) begin
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
        end
    end
`else
    logic ex_hit, exm_hit;

    assign ex_hit  = ex_valid && ex_reg_write && ex_rd != 5'd0 &&
                     (ex_rd == id_rs1 || ex_rd == id_rs2);
    assign exm_hit = exm_reg_write && exm_rd != 5'd0 &&
                     (exm_rd == id_rs1 || exm_rd == id_rs2);
    assign hazard  = id_valid && (ex_hit || exm_hit);
    // Producer in EX needs two cycles to reach WB, in EX/MEM only one.
    assign hz_bubbles = ex_hit ? 2'd2 : 2'd1;

    assign ex_op1 = ex_v1;
    assign ex_op2 = ex_v2;

    logic unused_exm;
    assign unused_exm = ^exm_result;
`endif

    // In STALL, further bubbles are owed only while the counter is nonzero;
    // with a zero counter the held instruction is released into EX.
    assign stall_raw = (state == S_RUN) ? hazard : (cnt != 2'd0);
    assign stall_o   = stall_raw && en && !flush && !RST;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state        <= S_RUN;
            cnt          <= '0;
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_v1        <= '0;
            ex_v2        <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_ctrl      <= '0;
        end else if (en) begin
            ex_v1   <= cap1;
            ex_v2   <= cap2;
            ex_imm  <= id_imm;
            ex_rd   <= id_rd;
            ex_ctrl <= id_ctrl;
            if (flush) begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                state        <= S_RUN;
                cnt          <= '0;
            end else if (stall_raw) begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                state        <= S_STALL;
                cnt          <= (state == S_RUN) ? 2'(hz_bubbles - 2'd1) : 2'(cnt - 2'd1);
            end else begin
                ex_valid     <= id_valid;
                ex_reg_write <= id_valid && id_reg_write;
                ex_mem_read  <= id_valid && id_mem_read;
                state        <= S_RUN;
                cnt          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        RST, en, flush, id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, wb_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm, exm_result, wb_data;
    logic [7:0]  id_ctrl;
    logic        id_mem_read, id_reg_write, exm_reg_write, wb_reg_write;
    logic        stall_o, ex_valid, ex_mem_read, ex_reg_write;
    logic [31:0] ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd;
    logic [7:0]  ex_ctrl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (
        .clk(clk), .RST(RST), .en(en), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample one time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic mr, input logic rw);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rdata1 = d1; id_rdata2 = d2; id_mem_read = mr; id_reg_write = rw;
    endtask

    initial begin
        RST = 1'b1; en = 1'b1; flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        id_imm = 32'h0; id_ctrl = 8'h0;
        exm_rd = 5'd0; exm_reg_write = 1'b0; exm_result = 32'h0;
        wb_rd = 5'd0; wb_reg_write = 1'b0; wb_data = 32'h0;

        // ---- reset state
        tick();
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ex_op1", ex_op1, 32'h0);
        chk("rst_ex_imm", ex_imm, 32'h0);
        chk("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
        chk("rst_ex_rw", {31'b0, ex_reg_write}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        RST = 1'b0;

        // ---- plain capture, 1-cycle latency
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 1'b0, 1'b1);
        id_imm = 32'hFFFF_FFF0; id_ctrl = 8'hA5;
        #1 chk("cap_nostall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("cap_valid", {31'b0, ex_valid}, 32'd1);
        chk("cap_op1", ex_op1, 32'h100);
        chk("cap_op2", ex_op2, 32'h200);
        chk("cap_imm", ex_imm, 32'hFFFF_FFF0);
        chk("cap_rd", {27'b0, ex_rd}, 32'd3);
        chk("cap_ctrl", {24'b0, ex_ctrl}, 32'hA5);
        chk("cap_rw", {31'b0, ex_reg_write}, 32'd1);

        // ---- id_valid=0 loads a bubble, reg_write forced 0
        set_id(1'b0, 5'd3, 5'd0, 5'd4, 32'h0, 32'h0, 1'b1, 1'b1);
        #1 chk("bub_nostall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("bub_valid", {31'b0, ex_valid}, 32'd0);
        chk("bub_rw", {31'b0, ex_reg_write}, 32'd0);
        chk("bub_mr", {31'b0, ex_mem_read}, 32'd0);

        // ---- ID write-through from MEM/WB
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'h0, 32'h44, 1'b0, 1'b0);
        wb_rd = 5'd3; wb_reg_write = 1'b1; wb_data = 32'hDEAD;
        tick();
        wb_reg_write = 1'b0; wb_data = 32'h0;
        #1 chk("wt_op1", ex_op1, 32'hDEAD);
        chk("wt_op2", ex_op2, 32'h44);

        // ---- x0 source / x0 producer
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h77, 32'h88, 1'b0, 1'b0);
        exm_rd = 5'd0; exm_reg_write = 1'b1; exm_result = 32'h55;
        wb_rd = 5'd0; wb_reg_write = 1'b1; wb_data = 32'h99;
        #1 chk("x0_nostall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("x0_op1", ex_op1, 32'h0);
        chk("x0_op2", ex_op2, 32'h0);
        exm_reg_write = 1'b0; exm_result = 32'h0; wb_reg_write = 1'b0; wb_data = 32'h0;

`ifdef RVL_ID_EX_FORWARDING_EN
        // ---- ALU chain: x1=0x11 in EX/MEM, ID add x2,x1,x0
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h0, 32'h0, 1'b0, 1'b1);
        exm_rd = 5'd1; exm_reg_write = 1'b1; exm_result = 32'h11;
        #1 chk("alu_nostall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("alu_op1_exm", ex_op1, 32'h11);
        chk("alu_nostall2", {31'b0, stall_o}, 32'd0);
        wb_rd = 5'd1; wb_reg_write = 1'b1; wb_data = 32'h22;
        #1 chk("fwd_prio_exm", ex_op1, 32'h11);
        exm_reg_write = 1'b0;
        #1 chk("fwd_wb", ex_op1, 32'h22);
        wb_reg_write = 1'b0;
        #1 chk("fwd_none", ex_op1, 32'h0);

        // ---- load-use: lw x5 in EX, ID add x6,x5,x5
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 5'd6, 32'h0, 32'h0, 1'b0, 1'b1);
        #1 chk("lu_stall", {31'b0, stall_o}, 32'd1);
        tick();
        chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
        exm_rd = 5'd5; exm_reg_write = 1'b1; exm_result = 32'h1000;
        #1 chk("lu_stall_once", {31'b0, stall_o}, 32'd0);
        tick();
        exm_reg_write = 1'b0; exm_result = 32'h0;
        wb_rd = 5'd5; wb_reg_write = 1'b1; wb_data = 32'hCAFE;
        #1 chk("lu_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_op1", ex_op1, 32'hCAFE);
        chk("lu_op2", ex_op2, 32'hCAFE);
        chk("lu_nostall", {31'b0, stall_o}, 32'd0);
        wb_reg_write = 1'b0; wb_data = 32'h0;
`else
        // ---- no forwarding: add x1 then add x2,x1 back-to-back
        set_id(1'b1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 5'd1, 5'd0, 5'd2, 32'h0, 32'h0, 1'b0, 1'b1);
        #1 chk("raw_stall1", {31'b0, stall_o}, 32'd1);
        tick();
        chk("raw_bub1", {31'b0, ex_valid}, 32'd0);
        exm_rd = 5'd1; exm_reg_write = 1'b1; exm_result = 32'h11;
        #1 chk("raw_stall2", {31'b0, stall_o}, 32'd1);
        tick();
        chk("raw_bub2", {31'b0, ex_valid}, 32'd0);
        exm_reg_write = 1'b0; exm_result = 32'h0;
        wb_rd = 5'd1; wb_reg_write = 1'b1; wb_data = 32'h11;
        #1 chk("raw_release", {31'b0, stall_o}, 32'd0);
        tick();
        wb_reg_write = 1'b0; wb_data = 32'h0;
        #1 chk("raw_valid", {31'b0, ex_valid}, 32'd1);
        chk("raw_op1", ex_op1, 32'h11);
        chk("raw_rd", {27'b0, ex_rd}, 32'd2);

        // ---- producer in EX/MEM only: 1 bubble
        set_id(1'b1, 5'd0, 5'd7, 5'd8, 32'h0, 32'h0, 1'b0, 1'b0);
        exm_rd = 5'd7; exm_reg_write = 1'b1; exm_result = 32'h3;
        #1 chk("exm_stall", {31'b0, stall_o}, 32'd1);
        tick();
        chk("exm_bub", {31'b0, ex_valid}, 32'd0);
        exm_reg_write = 1'b0;
        wb_rd = 5'd7; wb_reg_write = 1'b1; wb_data = 32'h77;
        #1 chk("exm_release", {31'b0, stall_o}, 32'd0);
        tick();
        wb_reg_write = 1'b0; wb_data = 32'h0;
        #1 chk("exm_op2", ex_op2, 32'h77);
        chk("exm_valid", {31'b0, ex_valid}, 32'd1);
`endif

        // ---- flush during a hazard (load producer stalls in both builds)
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 5'd6, 32'h0, 32'h0, 1'b0, 1'b1);
        #1 chk("fl_stall", {31'b0, stall_o}, 32'd1);
        flush = 1'b1;
        #1 chk("fl_mask", {31'b0, stall_o}, 32'd0);
        tick();
        flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 chk("fl_valid", {31'b0, ex_valid}, 32'd0);
        chk("fl_run", {31'b0, stall_o}, 32'd0);

        // ---- en=0 holds state and masks stall
        id_imm = 32'h123; id_ctrl = 8'h3C;
        set_id(1'b1, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd10, 5'd0, 5'd11, 32'h0, 32'h0, 1'b0, 1'b1);
        en = 1'b0;
        #1 chk("en0_nostall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("en0_hold_rd", {27'b0, ex_rd}, 32'd10);
        chk("en0_hold_vld", {31'b0, ex_valid}, 32'd1);
        en = 1'b1;
        #1 chk("en1_stall", {31'b0, stall_o}, 32'd1);

        // ---- reset asserted mid-STALL
        tick();
        chk("ms_bubble", {31'b0, ex_valid}, 32'd0);
        chk("ms_imm", ex_imm, 32'h123);
        RST = 1'b1;
        #1 chk("ms_rst_imm", ex_imm, 32'h0);
        chk("ms_rst_rd", {27'b0, ex_rd}, 32'd0);
        chk("ms_rst_ctrl", {24'b0, ex_ctrl}, 32'd0);
        chk("ms_rst_stall", {31'b0, stall_o}, 32'd0);
        chk("ms_rst_op1", ex_op1, 32'h0);
        tick();
        RST = 1'b0;
        #1 chk("ms_run", {31'b0, stall_o}, 32'd0);
        tick();
        chk("ms_after_valid", {31'b0, ex_valid}, 32'd1);
        chk("ms_after_rd", {27'b0, ex_rd}, 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
